serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits; legal range 2..16.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  request to begin an operation on numA/numB.
REQ-005 Port: numA  input  WIDTH  operand A, sampled only on the accepting edge.
REQ-006 Port: numB  input  WIDTH  operand B, sampled only on the accepting edge.
REQ-007 Port: op  input  1  0 = add, 1 = subtract; present only when SUBTRACAO_EN is defined.
REQ-008 Port: busy  output  1  high while bits are being processed.
REQ-009 Port: done  output  1  registered one-cycle pulse marking a new valid resultado.
REQ-010 Port: resultado  output  WIDTH+1  result; bit WIDTH is the final carry-out.

Function
REQ-011 The block SHALL compute the sum bit-serially with one internal 1-bit full-adder cell (A, B, Cin -> S, Cout), LSB first, one bit per clock.
REQ-012 FSM states SHALL be OCIOSO (idle), SOMANDO (processing) and CONCLUIDO (done).
REQ-013 In OCIOSO or CONCLUIDO, start=1 on an edge SHALL load numA and numB into operand shift registers, clear the bit counter, load the carry register (0 for add), and enter SOMANDO.
REQ-014 In OCIOSO or CONCLUIDO, start=0 SHALL move to or stay in OCIOSO.
REQ-015 Each SOMANDO edge SHALL add the operand LSBs plus the carry register, shift the sum bit into a partial-result register from the MSB side, shift both operands right by one, store Cout, and increment the counter.
REQ-016 On the SOMANDO edge that processes bit WIDTH-1, the block SHALL write {final Cout, partial sum} to resultado, pulse done, and enter CONCLUIDO.
REQ-017 Latency: done SHALL be high in the cycle after edge N+WIDTH, where N is the edge that accepted start.
REQ-018 busy SHALL be 1 exactly while in SOMANDO; done SHALL be 1 exactly while in CONCLUIDO; they are never high together.
REQ-019 start while in SOMANDO SHALL be ignored, with no queuing and no effect on the operation in flight.
REQ-020 resultado SHALL hold its last value while busy and SHALL change only at completion or reset.
REQ-021 Arithmetic SHALL be unsigned, with no saturation; resultado equals numA+numB exactly in WIDTH+1 bits.
REQ-022 Changes on numA, numB or op after the accepting edge SHALL NOT affect the operation in flight.

Reset
REQ-023 rst=1 on an edge SHALL force OCIOSO, busy=0, done=0, resultado=0, with operand, carry and counter registers cleared.
REQ-024 rst SHALL take priority over start and over any state transition.
REQ-025 rst during SOMANDO SHALL abort the operation; no done pulse follows and resultado stays 0.

Configuration
REQ-026 Macro SUBTRACAO_EN SHALL compile in subtraction support.
REQ-027 With SUBTRACAO_EN defined: the op port exists; op=1 at acceptance loads the carry register with 1, and every numB bit is inverted before the adder cell.
REQ-028 In subtract mode, resultado SHALL equal numA + ~numB + 1 in WIDTH+1 bits, with bit WIDTH = 1 meaning no borrow.
REQ-029 Without SUBTRACAO_EN: the op port is absent, no inversion logic exists, and the carry register always loads 0.

Verification
REQ-030 WIDTH=4, start with numA=3, numB=5 -> busy high for 4 cycles, then done pulses one cycle with resultado=5'b01000.
REQ-031 numA=15, numB=15 -> resultado=5'b11110, done one cycle; resultado holds 5'b11110 until the next completion.
REQ-032 start again in the second SOMANDO cycle with numA=1, numB=1 -> ignored; the first result (3+5=8) completes on schedule.
REQ-033 rst asserted during the third SOMANDO cycle -> next cycle busy=0, done=0, resultado=0; no done pulse afterwards.
REQ-034 start held high through CONCLUIDO with new operands 2+2 -> accepted directly from CONCLUIDO; resultado=5'b00100 exactly WIDTH cycles later.
REQ-035 SUBTRACAO_EN defined, op=1, numA=5, numB=3 -> resultado=5'b10010; with numA=3, numB=5 -> resultado=5'b01110 (borrow).

Source files
------------

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial unsigned adder, one full-adder cell, LSB first
// Optional subtraction (numA - numB via inverted numB and carry-in 1) with SUBTRACAO_EN.
module serial_add_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] numA,
    input  logic [WIDTH-1:0] numB,
`ifdef SUBTRACAO_EN
    input  logic             op,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   resultado
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int PW    = WIDTH - 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        OCIOSO,
        SOMANDO,
        CONCLUIDO
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    partial_q, partial_d;
    logic [WIDTH:0]   resultado_q, resultado_d;
    logic             done_q, done_d;
`ifdef SUBTRACAO_EN
    logic             op_q, op_d;
`endif

    logic b_bit;
    logic sum_bit;
    logic cout_bit;

    always_comb begin
`ifdef SUBTRACAO_EN
        b_bit = b_q[0] ^ op_q;
`else
        b_bit = b_q[0];
`endif
        sum_bit  = a_q[0] ^ b_bit ^ carry_q;
        cout_bit = (a_q[0] & b_bit) | (carry_q & (a_q[0] ^ b_bit));
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        partial_d   = partial_q;
        resultado_d = resultado_q;
        done_d      = 1'b0;
`ifdef SUBTRACAO_EN
        op_d        = op_q;
`endif
        case (state_q)
            SOMANDO: begin
                // partial keeps the WIDTH-1 most recent sum bits; the newest enters at the top
                partial_d = PW'({sum_bit, partial_q} >> 1);
                a_d       = {1'b0, a_q[WIDTH-1:1]};
                b_d       = {1'b0, b_q[WIDTH-1:1]};
                carry_d   = cout_bit;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    resultado_d = {cout_bit, sum_bit, partial_q};
                    done_d      = 1'b1;
                    state_d     = CONCLUIDO;
                end
            end
            default: begin
                if (start) begin
                    a_d     = numA;
                    b_d     = numB;
                    cnt_d   = '0;
`ifdef SUBTRACAO_EN
                    op_d    = op;
                    carry_d = op;
`else
                    carry_d = 1'b0;
`endif
                    state_d = SOMANDO;
                end else begin
                    state_d = OCIOSO;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= OCIOSO;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            partial_q   <= '0;
            resultado_q <= '0;
            done_q      <= 1'b0;
`ifdef SUBTRACAO_EN
            op_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            partial_q   <= partial_d;
            resultado_q <= resultado_d;
            done_q      <= done_d;
`ifdef SUBTRACAO_EN
            op_q        <= op_d;
`endif
        end
    end

    assign busy      = (state_q == SOMANDO);
    assign done      = done_q;
    assign resultado = resultado_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl (table, random and corner sequences)
module tb_serial_add_ctrl;

    localparam int WIDTH = 4;
    localparam int MASK  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] numA;
    logic [WIDTH-1:0] numB;
`ifdef SUBTRACAO_EN
    logic             op;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH:0]   resultado;

    int checks   = 0;
    int failures = 0;
    logic [WIDTH:0] held;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             o;
        logic [WIDTH:0]   exp;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .numA      (numA),
        .numB      (numB),
`ifdef SUBTRACAO_EN
        .op        (op),
`endif
        .busy      (busy),
        .done      (done),
        .resultado (resultado)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic o);
`ifdef SUBTRACAO_EN
        op = o;
`endif
    endtask

    function automatic logic [WIDTH:0] model(input int a, input int b, input logic o);
        int r;
        if (o) r = a + ((~b) & MASK) + 1;
        else   r = a + b;
        return (WIDTH+1)'(r);
    endfunction

    // Accept an operation, scramble inputs in flight, check busy window and the completion cycle.
    // poke=1 re-asserts start with 1+1 during the second processing cycle.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic o, input logic [WIDTH:0] exp, input bit poke);
        start = 1'b1;
        numA  = a;
        numB  = b;
        drive_op(o);
        tick();
        start = 1'b0;
        numA  = WIDTH'($urandom);
        numB  = WIDTH'($urandom);
        drive_op(1'($urandom));
        for (int i = 0; i < WIDTH; i++) begin
            check("busy_in_flight", busy, 1);
            check("done_in_flight", done, 0);
            check("result_hold", resultado, held);
            if (poke && i == 1) begin
                start = 1'b1;
                numA  = 1;
                numB  = 1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check("done_pulse", done, 1);
        check("busy_at_done", busy, 0);
        check("result", resultado, exp);
        held = exp;
    endtask

    task automatic go_idle();
        start = 1'b0;
        tick();
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
        check("idle_result", resultado, held);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        numA  = '0;
        numB  = '0;
        drive_op(1'b0);
        held  = '0;

        vecs.push_back('{a: 3,  b: 5,  o: 1'b0, exp: 5'b01000});
        vecs.push_back('{a: 15, b: 15, o: 1'b0, exp: 5'b11110});
        vecs.push_back('{a: 0,  b: 0,  o: 1'b0, exp: 5'b00000});
        vecs.push_back('{a: 15, b: 1,  o: 1'b0, exp: 5'b10000});
        vecs.push_back('{a: 10, b: 5,  o: 1'b0, exp: 5'b01111});
`ifdef SUBTRACAO_EN
        vecs.push_back('{a: 5,  b: 3,  o: 1'b1, exp: 5'b10010});
        vecs.push_back('{a: 3,  b: 5,  o: 1'b1, exp: 5'b01110});
        vecs.push_back('{a: 7,  b: 7,  o: 1'b1, exp: 5'b10000});
`endif

        start = 1'b1;
        numA  = 9;
        numB  = 9;
        tick();
        start = 1'b0;
        tick();
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", resultado, 0);
        rst = 1'b0;

        foreach (vecs[k]) begin
            run_op(vecs[k].a, vecs[k].b, vecs[k].o, vecs[k].exp, 1'b0);
            go_idle();
        end

        // Back-to-back: start held through CONCLUIDO is accepted directly.
        run_op(3, 5, 1'b0, 5'b01000, 1'b0);
        run_op(2, 2, 1'b0, 5'b00100, 1'b0);
        go_idle();

        // Start during processing is ignored.
        run_op(3, 5, 1'b0, 5'b01000, 1'b1);
        go_idle();
        go_idle();

        // Reset in the third processing cycle aborts without a done pulse.
        start = 1'b1;
        numA  = 3;
        numB  = 5;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", resultado, 0);
        held = '0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            tick();
            check("abort_no_done", done, 0);
            check("abort_result_hold", resultado, 0);
        end

        for (int n = 0; n < 40; n++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            logic             ro;
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
`ifdef SUBTRACAO_EN
            ro = 1'($urandom);
`else
            ro = 1'b0;
`endif
            run_op(ra, rb, ro, model(int'(ra), int'(rb), ro), 1'b0);
            if ($urandom_range(0, 1) == 1) go_idle();
        end
        go_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
